ioctl_dl_router: RTL and testbench

//  Successor to the fixed 14-bit, 8-bit-wide ROM download hookup in the sim/MiSTer top level.

---
 rtl/ioctl_dl_router_if.sv | 26 ++
 rtl/ioctl_dl_router.sv | 166 ++++++++++++++++
 tb/tb_ioctl_dl_router.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ioctl_dl_router_if.sv
// ioctl_dl_router_if: HPS ioctl byte bus plus the packed region write bus
interface ioctl_dl_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int REGION_AW   = 14,
    parameter int DATA_W      = 8
);
    localparam int AW = REGION_AW - $clog2(DATA_W / 8);
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic                   ioctl_wait;
    logic [AW-1:0]          dn_addr;
    logic [DATA_W-1:0]      dn_data;
    logic [NUM_REGIONS-1:0] dn_we;
    logic                   dn_ready;
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dn_ready,
        input  ioctl_wait, dn_addr, dn_data, dn_we
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dn_ready,
        output ioctl_wait, dn_addr, dn_data, dn_we
    );
endinterface

// File: rtl/ioctl_dl_router.sv
// ioctl_dl_router: packs HPS download bytes into words, routes them to regions, holds core reset
module ioctl_dl_router #(
    parameter int         NUM_REGIONS = 4,
    parameter int         REGION_AW   = 14,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] ROM_INDEX   = 8'd0,
    parameter int         RESET_HOLD  = 16,
    parameter logic [7:0] PAD_BYTE    = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    ioctl_dl_router_if.slave  bus,
    output logic              core_reset,
    output logic              dl_done,
    output logic              dl_overflow,
    output logic [24:0]       byte_count
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int RB    = $clog2(NUM_REGIONS);
    localparam int LW    = (LB > 0) ? LB : 1;
    localparam int RW    = (RB > 0) ? RB : 1;
    localparam int AW    = REGION_AW - LB;
    localparam int CW    = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

    state_t                 st_q, st_d;
    logic                   dl_prev_q;
    logic [DATA_W-1:0]      word_q, word_d, dn_data_q, dn_data_d;
    logic [BYTES-1:0]       mask_q, mask_d;
    logic [AW-1:0]          wa_q, wa_d, dn_addr_q, dn_addr_d;
    logic [RW-1:0]          rg_q, rg_d;
    logic [NUM_REGIONS-1:0] dn_we_q, dn_we_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   core_reset_q, core_reset_d;
    logic                   dl_done_q, dl_done_d;
    logic                   dl_overflow_q, dl_overflow_d;
    logic [24:0]            byte_count_q, byte_count_d;

    logic              pending, accept, oob, rise, fall, free, last;
    logic [LW-1:0]     lane;
    logic [RW-1:0]     rg;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] packed_w, padded_w;

    assign pending        = |dn_we_q;
    assign bus.ioctl_wait = pending & ~bus.dn_ready;
    assign bus.dn_we      = dn_we_q;
    assign bus.dn_data    = dn_data_q;
    assign bus.dn_addr    = dn_addr_q;
    assign core_reset     = core_reset_q;
    assign dl_done        = dl_done_q;
    assign dl_overflow    = dl_overflow_q;
    assign byte_count     = byte_count_q;

    assign lane   = LW'(bus.ioctl_addr) & LW'(BYTES - 1);
    assign rg     = RW'(bus.ioctl_addr >> REGION_AW) & RW'(NUM_REGIONS - 1);
    assign wa     = AW'(bus.ioctl_addr >> LB);
    assign oob    = |(bus.ioctl_addr >> (REGION_AW + RB));
    assign rise   = ~dl_prev_q & bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
    assign fall   = dl_prev_q & ~bus.ioctl_download;
    assign accept = (st_q == LOAD) & bus.ioctl_wr & bus.ioctl_download &
                    (bus.ioctl_index == ROM_INDEX) & ~bus.ioctl_wait;
    assign last   = lane == LW'(BYTES - 1);
    // the output register may be reloaded in the same cycle its word is taken
    assign free   = ~pending | bus.dn_ready;

    always_comb begin
        packed_w = word_q;
        packed_w[8*int'(lane) +: 8] = bus.ioctl_dout;
        padded_w = word_q;
        for (int i = 0; i < BYTES; i++)
            padded_w[i*8 +: 8] = mask_q[i] ? word_q[i*8 +: 8] : PAD_BYTE;
    end

    always_comb begin
        st_d          = st_q;
        word_d        = word_q;
        mask_d        = mask_q;
        wa_d          = wa_q;
        rg_d          = rg_q;
        dn_data_d     = dn_data_q;
        dn_addr_d     = dn_addr_q;
        dn_we_d       = bus.dn_ready ? '0 : dn_we_q;
        cnt_d         = '0;
        dl_done_d     = 1'b0;
        dl_overflow_d = dl_overflow_q;
        byte_count_d  = byte_count_q;
        if (accept) begin
            byte_count_d = &byte_count_q ? byte_count_q : byte_count_q + 25'd1;
            if (oob) begin
                dl_overflow_d = 1'b1;
            end else begin
                word_d = packed_w;
                wa_d   = wa;
                rg_d   = rg;
                mask_d = mask_q | (BYTES'(1) << lane);
                if (last) begin
                    mask_d    = '0;
                    dn_data_d = packed_w;
                    dn_addr_d = wa;
                    dn_we_d   = NUM_REGIONS'(1) << rg;
                end
            end
        end
        case (st_q)
            IDLE: if (rise) begin
                st_d          = LOAD;
                byte_count_d  = '0;
                mask_d        = '0;
                dl_overflow_d = 1'b0;
            end
            LOAD: if (fall) st_d = |mask_q ? FLUSH : HOLD;
            FLUSH: if (free) begin
                dn_data_d = padded_w;
                dn_addr_d = wa_q;
                dn_we_d   = NUM_REGIONS'(1) << rg_q;
                mask_d    = '0;
                st_d      = HOLD;
            end
            HOLD: if (rise) begin
                st_d          = LOAD;
                byte_count_d  = '0;
                mask_d        = '0;
                dl_overflow_d = 1'b0;
            end else if (!pending) begin
                cnt_d     = (cnt_q == CW'(RESET_HOLD - 1)) ? '0 : cnt_q + CW'(1);
                st_d      = (cnt_q == CW'(RESET_HOLD - 1)) ? IDLE : HOLD;
                dl_done_d = cnt_q == CW'(RESET_HOLD - 1);
            end else begin
                cnt_d = cnt_q;
            end
        endcase
        core_reset_d = st_d != IDLE;
    end

    // download level is tracked through reset so a held download is not mistaken for a new one
    always_ff @(posedge clk_sys) begin
        dl_prev_q <= bus.ioctl_download;
        if (!reset_n) begin
            st_q          <= IDLE;
            mask_q        <= '0;
            dn_we_q       <= '0;
            cnt_q         <= '0;
            core_reset_q  <= 1'b1;
            dl_done_q     <= 1'b0;
            dl_overflow_q <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            st_q          <= st_d;
            word_q        <= word_d;
            mask_q        <= mask_d;
            wa_q          <= wa_d;
            rg_q          <= rg_d;
            dn_data_q     <= dn_data_d;
            dn_addr_q     <= dn_addr_d;
            dn_we_q       <= dn_we_d;
            cnt_q         <= cnt_d;
            core_reset_q  <= core_reset_d;
            dl_done_q     <= dl_done_d;
            dl_overflow_q <= dl_overflow_d;
            byte_count_q  <= byte_count_d;
        end
    end
endmodule

// File: tb/tb_ioctl_dl_router.sv
// tb_ioctl_dl_router: directed checks of three router widths sharing one ioctl stream
module tb_ioctl_dl_router;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl, strobe;
  logic [7:0]  idx, dout;
  logic [24:0] addr;
  logic        rdy8, rdy16, rdy32;
  logic        cr [3];
  logic        dd [3];
  logic        ov [3];
  logic [24:0] bc [3];
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  ioctl_dl_router_if #(.DATA_W(8))  b8  ();
  ioctl_dl_router_if #(.DATA_W(16)) b16 ();
  ioctl_dl_router_if #(.DATA_W(32)) b32 ();
  assign b8.ioctl_download  = dl;
  assign b8.ioctl_index     = idx;
  assign b8.ioctl_wr        = strobe;
  assign b8.ioctl_addr      = addr;
  assign b8.ioctl_dout      = dout;
  assign b8.dn_ready        = rdy8;
  assign b16.ioctl_download = dl;
  assign b16.ioctl_index    = idx;
  assign b16.ioctl_wr       = strobe;
  assign b16.ioctl_addr     = addr;
  assign b16.ioctl_dout     = dout;
  assign b16.dn_ready       = rdy16;
  assign b32.ioctl_download = dl;
  assign b32.ioctl_index    = idx;
  assign b32.ioctl_wr       = strobe;
  assign b32.ioctl_addr     = addr;
  assign b32.ioctl_dout     = dout;
  assign b32.dn_ready       = rdy32;
  ioctl_dl_router #(.DATA_W(8)) u8 (
    .clk_sys(clk), .reset_n(reset_n), .bus(b8.slave),
    .core_reset(cr[0]), .dl_done(dd[0]), .dl_overflow(ov[0]), .byte_count(bc[0]));
  ioctl_dl_router #(.DATA_W(16)) u16 (
    .clk_sys(clk), .reset_n(reset_n), .bus(b16.slave),
    .core_reset(cr[1]), .dl_done(dd[1]), .dl_overflow(ov[1]), .byte_count(bc[1]));
  ioctl_dl_router #(.DATA_W(32), .RESET_HOLD(5)) u32 (
    .clk_sys(clk), .reset_n(reset_n), .bus(b32.slave),
    .core_reset(cr[2]), .dl_done(dd[2]), .dl_overflow(ov[2]), .byte_count(bc[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    addr = a;
    dout = d;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask
  initial begin
    reset_n = 1'b0; dl = 1'b0; strobe = 1'b0; idx = 8'd0; dout = 8'd0; addr = '0;
    rdy8 = 1'b1; rdy16 = 1'b1; rdy32 = 1'b1;
    tick();
    tick();
    chk("rst_core_reset", cr[0], 1'b1);
    chk("rst_dn_we", b8.dn_we, 4'b0000);
    chk("rst_byte_count", bc[0], 25'd0);
    chk("rst_overflow", ov[0], 1'b0);
    chk("rst_dl_done", dd[0], 1'b0);
    reset_n = 1'b1;
    tick();
    chk("idle_core_reset", cr[0], 1'b0);
    dl = 1'b1;
    tick();
    chk("w8_load_core_reset", cr[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      wr(25'(i), 8'hA0 + 8'(i));
      chk("w8_we", b8.dn_we, 4'b0001);
      chk("w8_data", b8.dn_data, 8'hA0 + 8'(i));
      chk("w8_addr", b8.dn_addr, 14'(i));
      chk("w8_wait", b8.ioctl_wait, 1'b0);
    end
    chk("w8_count", bc[0], 25'd4);
    dl = 1'b0;
    pulse_reset();
    dl = 1'b1;
    tick();
    wr(25'h4002, 8'h11);
    chk("w16_half_we", b16.dn_we, 4'b0000);
    wr(25'h4003, 8'h22);
    chk("w16_we", b16.dn_we, 4'b0010);
    chk("w16_addr", b16.dn_addr, 13'd1);
    chk("w16_data", b16.dn_data, 16'h2211);
    rdy16 = 1'b0;
    addr = 25'h4004;
    dout = 8'h33;
    for (int i = 0; i < 5; i++) begin
      strobe = (i == 0);
      #1;
      chk("bp_wait", b16.ioctl_wait, 1'b1);
      tick();
    end
    strobe = 1'b0;
    chk("bp_hold_we", b16.dn_we, 4'b0010);
    chk("bp_hold_data", b16.dn_data, 16'h2211);
    chk("bp_count", bc[1], 25'd2);
    rdy16 = 1'b1;
    #1;
    chk("bp_release_wait", b16.ioctl_wait, 1'b0);
    tick();
    chk("bp_taken_we", b16.dn_we, 4'b0000);
    wr(25'h4005, 8'h44);
    chk("bp_stale_lane", b16.dn_data, 16'h4411);
    chk("bp_next_addr", b16.dn_addr, 13'd2);
    dl = 1'b0;
    pulse_reset();
    dl = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr(25'(i), 8'(i + 1));
      if (i == 3) chk("w32_word0", b32.dn_data, 32'h04030201);
    end
    chk("w32_partial_we", b32.dn_we, 4'b0000);
    chk("w32_count", bc[2], 25'd6);
    dl = 1'b0;
    tick();
    tick();
    chk("flush_we", b32.dn_we, 4'b0001);
    chk("flush_data", b32.dn_data, 32'hFFFF0605);
    chk("flush_addr", b32.dn_addr, 12'd1);
    tick();
    chk("flush_taken", b32.dn_we, 4'b0000);
    chk("tail_core_reset0", cr[2], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("tail_core_reset", cr[2], (i < 5));
      chk("tail_done", dd[2], (i == 5));
    end
    tick();
    chk("done_once", dd[2], 1'b0);
    chk("idle_after_tail", cr[2], 1'b0);
    pulse_reset();
    dl = 1'b1;
    tick();
    wr(25'h10000, 8'h55);
    chk("oob_we", b8.dn_we, 4'b0000);
    chk("oob_flag", ov[0], 1'b1);
    chk("oob_count", bc[0], 25'd1);
    rdy8 = 1'b0;
    wr(25'h0FFFF, 8'h66);
    chk("top_we", b8.dn_we, 4'b1000);
    chk("top_addr", b8.dn_addr, 14'h3FFF);
    chk("top_sticky", ov[0], 1'b1);
    chk("top_count", bc[0], 25'd2);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_we", b8.dn_we, 4'b0000);
    chk("mid_rst_core_reset", cr[0], 1'b1);
    chk("mid_rst_overflow", ov[0], 1'b0);
    chk("mid_rst_count", bc[0], 25'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_rst_idle", cr[0], 1'b0);
    chk("mid_rst_still_we", b8.dn_we, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
